pipe_collision_ctrl: RTL and testbench

- Game-flow initiator for the pipe-scroll block: it drives that block's Start/Stop/Ack handshake.
- Consumes the current in-scope pipe edges (left/right X, gap top/bottom Y) and the bird Y position.
- Detects bird/pipe and bird/floor collisions on each frame tick, halts scrolling, and tracks the high score.
- Sits between the button inputs, the bird physics block and the pipe-scroll block.

---
 rtl/pipe_collision_ctrl_pkg.sv | 27 ++
 rtl/pipe_collision_ctrl_edge_detect_rise.sv | 21 ++
 rtl/pipe_collision_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_collision_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_collision_ctrl_pkg.sv
// Shared types and constants for the game-flow / collision controller.
package pipe_collision_ctrl_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned EXT_W    = COORD_W + 1;
  localparam int unsigned SCORE_W  = 4;
  localparam int unsigned GRACE_W  = 4;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam logic [COORD_W-1:0] FLOOR_Y_DEF = 10'd464;

  typedef enum logic [2:0] {
    Q_IDLE = 3'b001,
    Q_PLAY = 3'b010,
    Q_OVER = 3'b100
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] bird_y;
    logic [COORD_W-1:0] x_edge_l;
    logic [COORD_W-1:0] x_edge_r;
    logic [COORD_W-1:0] gap_top;
    logic [COORD_W-1:0] gap_bot;
  } pipe_sample_t;

endpackage

// File: rtl/pipe_collision_ctrl_edge_detect_rise.sv
// Rising-edge detector; history resets to 1 so a button held through reset gives no edge.
module edge_detect_rise (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise_c
);

  logic prev_q;
  logic prev_d;

  always_comb prev_d = btn;

  always_ff @(posedge clk) begin
    if (!reset) prev_q <= 1'b1;
    else        prev_q <= prev_d;
  end

  assign rise_c = btn & ~prev_q;

endmodule

// File: rtl/pipe_collision_ctrl.sv
// Game-flow FSM: drives pipe-scroll Start/Stop/Ack, detects bird collisions per tick,
// and keeps the best score since reset.
module pipe_collision_ctrl
  import pipe_collision_ctrl_pkg::*;
#(
  parameter logic [COORD_W-1:0] BIRD_X_L    = 10'd200,
  parameter logic [COORD_W-1:0] BIRD_X_R    = 10'd220,
  parameter logic [COORD_W-1:0] BIRD_H      = 10'd16,
  parameter logic [COORD_W-1:0] FLOOR_Y     = FLOOR_Y_DEF,
  parameter logic [GRACE_W-1:0] GRACE_TICKS = 4'd8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               btn_start,
  input  logic               btn_ack,
  input  logic [COORD_W-1:0] bird_y,
  input  logic [COORD_W-1:0] x_edge_l,
  input  logic [COORD_W-1:0] x_edge_r,
  input  logic [COORD_W-1:0] gap_top,
  input  logic [COORD_W-1:0] gap_bot,
  input  logic [SCORE_W-1:0] score,
  output logic               start,
  output logic               stop,
  output logic               ack,
  output logic [SCORE_W-1:0] hi_score,
  output logic               q_idle,
  output logic               q_play,
  output logic               q_over
);

  state_t             state_q, state_d;
  logic               start_q, start_d;
  logic               stop_q, stop_d;
  logic               ack_q, ack_d;
  logic [SCORE_W-1:0] hi_score_q, hi_score_d;
  logic [GRACE_W-1:0] grace_q, grace_d;
  logic               chk_q, chk_d;
  logic               hs_upd_q, hs_upd_d;
  pipe_sample_t       smp_q, smp_d;

  logic               start_rise_c;
  logic               ack_rise_c;
  logic               xov_c;
  logic [EXT_W-1:0]   bot_c;
  logic               pipe_hit_c;
  logic               floor_hit_c;

  edge_detect_rise u_start_edge (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_start),
    .rise_c (start_rise_c)
  );

  edge_detect_rise u_ack_edge (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_ack),
    .rise_c (ack_rise_c)
  );

  // Collision terms evaluated on the samples registered at the previous tick.
  always_comb begin
    xov_c       = (smp_q.x_edge_l <= BIRD_X_R) && (smp_q.x_edge_r >= BIRD_X_L);
    bot_c       = EXT_W'(smp_q.bird_y) + EXT_W'(BIRD_H);
    pipe_hit_c  = xov_c && ((smp_q.bird_y < smp_q.gap_top) || (bot_c > EXT_W'(smp_q.gap_bot)));
    floor_hit_c = bot_c >= EXT_W'(FLOOR_Y);
  end

  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    stop_d     = stop_q;
    ack_d      = 1'b0;
    hi_score_d = hi_score_q;
    grace_d    = grace_q;
    chk_d      = 1'b0;
    hs_upd_d   = 1'b0;
    smp_d      = smp_q;

    case (state_q)
      Q_IDLE: begin
        stop_d = 1'b0;
        if (start_rise_c) begin
          start_d = 1'b1;
          grace_d = GRACE_TICKS;
          state_d = Q_PLAY;
        end
      end
      Q_PLAY: begin
        if (tick) begin
          smp_d = '{bird_y:   bird_y,   x_edge_l: x_edge_l, x_edge_r: x_edge_r,
                    gap_top:  gap_top,  gap_bot:  gap_bot};
          if (grace_q != '0) grace_d = grace_q - GRACE_W'(1);
          else               chk_d   = 1'b1;
        end
        if (chk_q && (pipe_hit_c || floor_hit_c)) begin
          stop_d   = 1'b1;
          hs_upd_d = 1'b1;
          chk_d    = 1'b0;
          state_d  = Q_OVER;
        end
      end
      Q_OVER: begin
        stop_d = 1'b1;
        if (hs_upd_q && (score > hi_score_q)) hi_score_d = score;
        if (ack_rise_c) begin
          ack_d   = 1'b1;
          stop_d  = 1'b0;
          state_d = Q_IDLE;
        end
      end
      default: begin
        stop_d  = 1'b0;
        state_d = Q_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= Q_IDLE;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      ack_q      <= 1'b0;
      hi_score_q <= '0;
      grace_q    <= '0;
      chk_q      <= 1'b0;
      hs_upd_q   <= 1'b0;
      smp_q      <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      ack_q      <= ack_d;
      hi_score_q <= hi_score_d;
      grace_q    <= grace_d;
      chk_q      <= chk_d;
      hs_upd_q   <= hs_upd_d;
      smp_q      <= smp_d;
    end
  end

  assign start    = start_q;
  assign stop     = stop_q;
  assign ack      = ack_q;
  assign hi_score = hi_score_q;
  assign q_idle   = (state_q == Q_IDLE);
  assign q_play   = (state_q == Q_PLAY);
  assign q_over   = (state_q == Q_OVER);

endmodule

// File: tb/tb_pipe_collision_ctrl.sv
// Directed bench for pipe_collision_ctrl: handshake, grace, pipe/floor hits, high score, reset.
module tb_pipe_collision_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       btn_start;
  logic       btn_ack;
  logic [9:0] bird_y;
  logic [9:0] x_edge_l;
  logic [9:0] x_edge_r;
  logic [9:0] gap_top;
  logic [9:0] gap_bot;
  logic [3:0] score;
  logic       start;
  logic       stop;
  logic       ack;
  logic [3:0] hi_score;
  logic       q_idle;
  logic       q_play;
  logic       q_over;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_collision_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .btn_start (btn_start),
    .btn_ack   (btn_ack),
    .bird_y    (bird_y),
    .x_edge_l  (x_edge_l),
    .x_edge_r  (x_edge_r),
    .gap_top   (gap_top),
    .gap_bot   (gap_bot),
    .score     (score),
    .start     (start),
    .stop      (stop),
    .ack       (ack),
    .hi_score  (hi_score),
    .q_idle    (q_idle),
    .q_play    (q_play),
    .q_over    (q_over)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One tick, then two idle cycles so its evaluation and any stop are visible.
  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    step();
  endtask

  task automatic press_ack();
    btn_ack = 1'b1;
    step();
    btn_ack = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; btn_start = 1'b1;
    step(); step();
    reset = 1'b1;
    step();
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %0b want 0", start); end
    checks++; if (stop !== 1'b0) begin errors++; $display("FAIL reset_stop: got %0b want 0", stop); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b want 0", ack); end
    checks++; if (hi_score !== 4'd0) begin errors++; $display("FAIL reset_hi: got %0d want 0", hi_score); end
    checks++; if ({q_idle, q_play, q_over} !== 3'b100) begin errors++; $display("FAIL reset_state: got %b want 100", {q_idle, q_play, q_over}); end
    step();
    checks++; if (start !== 1'b0 || q_idle !== 1'b1) begin errors++; $display("FAIL held_btn_no_start: got start=%0b idle=%0b want 0/1", start, q_idle); end
    btn_start = 1'b0;
    step();
    btn_start = 1'b1;
    step();
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL start_pulse: got %0b want 1", start); end
    checks++; if (q_play !== 1'b1) begin errors++; $display("FAIL start_q_play: got %0b want 1", q_play); end
    step();
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL start_one_cycle: got %0b want 0", start); end
    btn_start = 1'b0;
  endtask

  task automatic test_grace_pipe_hit();
    score = 4'd3;
    x_edge_l = 10'd180; x_edge_r = 10'd241; gap_top = 10'd200; gap_bot = 10'd300;
    bird_y = 10'd190;
    for (int i = 0; i < 8; i++) begin
      do_tick();
      checks++; if (stop !== 1'b0) begin errors++; $display("FAIL grace_tick%0d: got stop=%0b want 0", i, stop); end
    end
    bird_y = 10'd240;
    for (int i = 0; i < 2; i++) begin
      do_tick();
      checks++; if (stop !== 1'b0) begin errors++; $display("FAIL in_gap_tick%0d: got stop=%0b want 0", i, stop); end
    end
    bird_y = 10'd190;
    tick = 1'b1;
    step();
    tick = 1'b0;
    checks++; if (stop !== 1'b0) begin errors++; $display("FAIL pipe_hit_t1: got stop=%0b want 0", stop); end
    step();
    checks++; if (stop !== 1'b1) begin errors++; $display("FAIL pipe_hit_t2: got stop=%0b want 1", stop); end
    checks++; if (q_over !== 1'b1) begin errors++; $display("FAIL pipe_hit_over: got %0b want 1", q_over); end
    step();
    checks++; if (hi_score !== 4'd3) begin errors++; $display("FAIL hi_first: got %0d want 3", hi_score); end
  endtask

  task automatic test_ack();
    press_start();
    checks++; if (q_over !== 1'b1 || stop !== 1'b1) begin errors++; $display("FAIL over_ignores_start: got over=%0b stop=%0b want 1/1", q_over, stop); end
    btn_ack = 1'b1;
    step();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ack_pulse: got %0b want 1", ack); end
    checks++; if (stop !== 1'b0) begin errors++; $display("FAIL ack_stop_low: got %0b want 0", stop); end
    checks++; if (q_idle !== 1'b1) begin errors++; $display("FAIL ack_idle: got %0b want 1", q_idle); end
    step();
    btn_ack = 1'b0;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ack_one_cycle: got %0b want 0", ack); end
  endtask

  task automatic test_floor_hit();
    score = 4'd5;
    x_edge_l = 10'd500; x_edge_r = 10'd561; gap_top = 10'd200; gap_bot = 10'd300;
    bird_y = 10'd240;
    press_start();
    checks++; if (q_play !== 1'b1) begin errors++; $display("FAIL floor_game_play: got %0b want 1", q_play); end
    for (int i = 0; i < 8; i++) do_tick();
    bird_y = 10'd447;
    do_tick();
    checks++; if (stop !== 1'b0) begin errors++; $display("FAIL floor_463: got stop=%0b want 0", stop); end
    bird_y = 10'd448;
    do_tick();
    checks++; if (stop !== 1'b1 || q_over !== 1'b1) begin errors++; $display("FAIL floor_464: got stop=%0b over=%0b want 1/1", stop, q_over); end
    checks++; if (hi_score !== 4'd5) begin errors++; $display("FAIL hi_raise: got %0d want 5", hi_score); end
    press_ack();
  endtask

  task automatic test_back_to_back();
    score = 4'd2;
    x_edge_l = 10'd220; x_edge_r = 10'd281; gap_top = 10'd200; gap_bot = 10'd300;
    bird_y = 10'd240;
    press_start();
    for (int i = 0; i < 8; i++) do_tick();
    bird_y = 10'd200;
    tick = 1'b1;
    step();
    checks++; if (stop !== 1'b0) begin errors++; $display("FAIL b2b_e1: got stop=%0b want 0", stop); end
    bird_y = 10'd290;
    step();
    tick = 1'b0;
    checks++; if (stop !== 1'b0) begin errors++; $display("FAIL b2b_first_eval: got stop=%0b want 0", stop); end
    step();
    checks++; if (stop !== 1'b1) begin errors++; $display("FAIL b2b_second_hit: got stop=%0b want 1", stop); end
    step(); step();
    checks++; if (hi_score !== 4'd5) begin errors++; $display("FAIL hi_keep: got %0d want 5", hi_score); end
    press_ack();
  endtask

  task automatic test_reset_mid_play();
    bird_y = 10'd240;
    press_start();
    do_tick();
    checks++; if (q_play !== 1'b1) begin errors++; $display("FAIL mid_play: got %0b want 1", q_play); end
    reset = 1'b0;
    step();
    checks++; if (stop !== 1'b0 || hi_score !== 4'd0) begin errors++; $display("FAIL mid_reset_vals: got stop=%0b hi=%0d want 0/0", stop, hi_score); end
    checks++; if (q_idle !== 1'b1) begin errors++; $display("FAIL mid_reset_idle: got %0b want 1", q_idle); end
    reset = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; btn_start = 1'b0; btn_ack = 1'b0;
    bird_y = '0; x_edge_l = '0; x_edge_r = '0; gap_top = '0; gap_bot = '0; score = '0;
    test_reset();
    test_grace_pipe_hit();
    test_ack();
    test_floor_hit();
    test_back_to_back();
    test_reset_mid_play();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
